// File: rtl/display_scan_if.sv
// Bundle between the stopwatch datapath and the display scan controller:
// the BCD digits it shows and the anode/segment-code drive it produces.
interface display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  // Level signals, no valid/ready: inputs are sampled once per frame, and
  // outputs are registered and change only on clock edges.
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_blank;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output digits_bcd, dp_in, lz_blank,
    input  bcd_out, an, dp, frame_tick
  );

  modport slave (
    input  digits_bcd, dp_in, lz_blank,
    output bcd_out, an, dp, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner: snapshots the BCD vector once per frame and
// shows one digit per slot, blanking at the start of each slot against ghosting.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic           clk,
  input  logic           rst,
  display_scan_if.slave  bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

  logic [CW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap_bcd;
  logic [NUM_DIGITS-1:0]   snap_dp;

  phase_t                  phase;
  logic                    slot_last;
  logic                    snap_en;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   one_hot;

  assign phase     = (slot_cnt < BLANK_LIM) ? PH_BLANK : PH_SHOW;
  assign slot_last = (slot_cnt == LAST_SLOT);
  assign snap_en   = (slot_cnt == '0) && (idx == '0);
  assign cur_digit = snap_bcd[4*idx +: 4];
  assign one_hot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  // Digit i is a leading zero when it and every more significant digit are
  // zero; codes A..F count as non-zero. Digit 0 is always shown.
  always_comb begin
    upper_zero = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (snap_bcd[4*i +: 4] == 4'h0);
      supp[i]    = bus.lz_blank & upper_zero & (i != 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else if (snap_en) begin
      snap_bcd <= bus.digits_bcd;
      snap_dp  <= bus.dp_in;
    end
  end

  // Outputs are registered from pre-edge state, so nothing reaches the pins
  // combinationally from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an         <= '1;
      bus.bcd_out    <= 4'hF;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      if (phase == PH_BLANK) begin
        bus.an      <= '1;
        bus.bcd_out <= 4'hF;
        bus.dp      <= 1'b1;
      end else begin
        bus.an      <= ~one_hot;
        bus.bcd_out <= supp[idx] ? 4'hF : cur_digit;
        bus.dp      <= ~snap_dp[idx];
      end
      bus.frame_tick <= slot_last && (idx == LAST_IDX);
    end
  end
endmodule
